rv32i_test_ctrl: RTL and testbench

Synthesizable test-run controller for the rv32i core and multi-hart derivatives. On a start pulse it holds the core(s) in reset for a parametrised number of cycles, releases them, counts run cycles and watches each hart's ecall strobe. At each hart's first ecall it samples that hart's gp register (x3) and classifies the hart as pass or fail. It reports an overall pass/fail/timeout result and halts the DUT. It sits between the bench/DII harness and the core, with per-hart channels, a programmable timeout and a wait-all mode.

---
 rtl/rv32i_test_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_rv32i_test_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_test_ctrl.sv
// ---------------------------------------------------------------------------
// rv32i_test_ctrl
//
// Test-run controller that sits between the bench/DII harness and one or
// more rv32i harts. A start pulse holds the core(s) in reset for
// RESET_CYCLES cycles. The controller then releases them and counts run
// cycles. It records each hart's first ecall together with whether that
// hart's gp (x3) held PASS_VALUE at that moment. When the run completes,
// fails or times out, it halts the core(s) and reports an overall result.
//
// Ports
//   clk_i            clock, all state changes on the rising edge
//   rst_i            synchronous active-high reset (aborts any run)
//   start_i          single-cycle request to begin a run (IDLE/DONE only)
//   wait_all_i       1: finish when every hart has ecalled, 0: on first ecall
//   timeout_limit_i  max run cycles, 0 disables the timeout
//   ecall_i          per-hart ecall strobe
//   gp_i             per-hart x3 value, hart h at [h*XLEN +: XLEN]
//   core_rst_n_o     active-low reset to the core(s)
//   halt_o           halt request to the core(s)/DII
//   busy_o           run in progress (RESET or RUN)
//   done_o           result_o is valid
//   result_o         00 none, 01 pass, 10 fail, 11 timeout
//   hart_done_o      hart has ecalled during this run
//   hart_pass_o      hart's gp equalled PASS_VALUE at its first ecall
//   cycles_o         run-cycle count
// ---------------------------------------------------------------------------
module rv32i_test_ctrl #(
  parameter int unsigned          NUM_HARTS    = 1,
  parameter int unsigned          XLEN         = 32,
  parameter int unsigned          RESET_CYCLES = 10,
  parameter int unsigned          CNT_W        = 16,
  parameter logic [XLEN-1:0]      PASS_VALUE   = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      wait_all_i,
  input  logic [CNT_W-1:0]          timeout_limit_i,
  input  logic [NUM_HARTS-1:0]      ecall_i,
  input  logic [NUM_HARTS*XLEN-1:0] gp_i,
  output logic                      core_rst_n_o,
  output logic                      halt_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [1:0]                result_o,
  output logic [NUM_HARTS-1:0]      hart_done_o,
  output logic [NUM_HARTS-1:0]      hart_pass_o,
  output logic [CNT_W-1:0]          cycles_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] RES_NONE    = 2'b00;
  localparam logic [1:0] RES_PASS    = 2'b01;
  localparam logic [1:0] RES_FAIL    = 2'b10;
  localparam logic [1:0] RES_TIMEOUT = 2'b11;

  // The reset counter only has to reach RESET_CYCLES-1.
  localparam int unsigned      RST_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [RST_W-1:0]       rstCnt_q, rstCnt_d;
  logic [CNT_W-1:0]       cycles_q, cycles_d;
  logic [CNT_W-1:0]       limit_q, limit_d;
  logic                   waitAll_q, waitAll_d;
  logic [NUM_HARTS-1:0]   hartDone_q, hartDone_d;
  logic [NUM_HARTS-1:0]   hartPass_q, hartPass_d;
  logic [1:0]             result_q, result_d;

  logic [NUM_HARTS-1:0]   gpPass;
  logic [NUM_HARTS-1:0]   newDone;
  logic [NUM_HARTS-1:0]   recDone;
  logic [NUM_HARTS-1:0]   recPass;

  // Per-hart comparison of the sampled gp against the pass value. This is
  // only meaningful on the cycle that hart's first ecall is recorded.
  always_comb begin
    gpPass = '0;
    for (int h = 0; h < int'(NUM_HARTS); h++) begin
      gpPass[h] = (gp_i[h*XLEN +: XLEN] == PASS_VALUE);
    end
  end

  // Only the first ecall per hart counts. The recorded view (recDone/recPass)
  // already includes this cycle's new ecalls. The completion check sees the
  // same state the outputs will show one edge later.
  assign newDone = ecall_i & ~hartDone_q;
  assign recDone = hartDone_q | newDone;
  assign recPass = hartPass_q | (newDone & gpPass);

  // Next-state logic. A start in IDLE or DONE clears all status and latches
  // the run configuration. RESET simply counts. RUN records ecalls and decides
  // between completion and timeout. A completing ecall takes priority over a
  // timeout that falls on the same cycle.
  always_comb begin
    state_d    = state_q;
    rstCnt_d   = rstCnt_q;
    cycles_d   = cycles_q;
    limit_d    = limit_q;
    waitAll_d  = waitAll_q;
    hartDone_d = hartDone_q;
    hartPass_d = hartPass_q;
    result_d   = result_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d    = RESET;
          rstCnt_d   = '0;
          cycles_d   = '0;
          hartDone_d = '0;
          hartPass_d = '0;
          result_d   = RES_NONE;
          waitAll_d  = wait_all_i;
          limit_d    = timeout_limit_i;
        end
      end

      RESET: begin
        if (rstCnt_q == RST_LAST) begin
          state_d = RUN;
        end else begin
          rstCnt_d = rstCnt_q + 1'b1;
        end
      end

      RUN: begin
        // Saturating count. With a nonzero limit the run ends before the
        // count can wrap, so saturation only matters with the timeout disabled.
        if (cycles_q != '1) begin
          cycles_d = cycles_q + 1'b1;
        end
        hartDone_d = recDone;
        hartPass_d = recPass;

        if (!waitAll_q && (|newDone)) begin
          state_d  = DONE;
          result_d = ((newDone & ~gpPass) == '0) ? RES_PASS : RES_FAIL;
        end else if (waitAll_q && (&recDone)) begin
          state_d  = DONE;
          result_d = (&recPass) ? RES_PASS : RES_FAIL;
        end else if ((limit_q != '0) && (cycles_q == (limit_q - 1'b1))) begin
          state_d  = DONE;
          result_d = RES_TIMEOUT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and status registers. A synchronous reset returns everything to
  // IDLE with cleared status, which aborts any run in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rstCnt_q   <= '0;
      cycles_q   <= '0;
      limit_q    <= '0;
      waitAll_q  <= 1'b0;
      hartDone_q <= '0;
      hartPass_q <= '0;
      result_q   <= RES_NONE;
    end else begin
      state_q    <= state_d;
      rstCnt_q   <= rstCnt_d;
      cycles_q   <= cycles_d;
      limit_q    <= limit_d;
      waitAll_q  <= waitAll_d;
      hartDone_q <= hartDone_d;
      hartPass_q <= hartPass_d;
      result_q   <= result_d;
    end
  end

  // Core control follows directly from the state. The core is out of reset
  // once running and stays out of reset in DONE, so its final state can be
  // inspected. It is halted whenever no run is active.
  assign core_rst_n_o = (state_q == RUN)  || (state_q == DONE);
  assign halt_o       = (state_q == IDLE) || (state_q == DONE);
  assign busy_o       = (state_q == RESET) || (state_q == RUN);
  assign done_o       = (state_q == DONE);
  assign result_o     = result_q;
  assign hart_done_o  = hartDone_q;
  assign hart_pass_o  = hartPass_q;
  assign cycles_o     = cycles_q;

endmodule

// File: tb/tb_rv32i_test_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rv32i_test_ctrl
//
// Directed bench for rv32i_test_ctrl. It uses two instances:
//   dut1 : single hart, RESET_CYCLES = 10
//   dut4 : four harts,  RESET_CYCLES = 4
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_rv32i_test_ctrl;

  logic clk;

  // single-hart instance
  logic        rst1, start1, waitAll1;
  logic [15:0] limit1;
  logic [0:0]  ecall1;
  logic [31:0] gp1;
  logic        coreRstN1, halt1, busy1, done1;
  logic [1:0]  result1;
  logic [0:0]  hartDone1, hartPass1;
  logic [15:0] cycles1;

  // four-hart instance
  logic         rst4, start4, waitAll4;
  logic [15:0]  limit4;
  logic [3:0]   ecall4;
  logic [127:0] gp4;
  logic         coreRstN4, halt4, busy4, done4;
  logic [1:0]   result4;
  logic [3:0]   hartDone4, hartPass4;
  logic [15:0]  cycles4;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;
  int lowCycles;

  rv32i_test_ctrl #(
    .NUM_HARTS(1), .XLEN(32), .RESET_CYCLES(10), .CNT_W(16), .PASS_VALUE(32'd1)
  ) dut1 (
    .clk_i(clk), .rst_i(rst1), .start_i(start1), .wait_all_i(waitAll1),
    .timeout_limit_i(limit1), .ecall_i(ecall1), .gp_i(gp1),
    .core_rst_n_o(coreRstN1), .halt_o(halt1), .busy_o(busy1), .done_o(done1),
    .result_o(result1), .hart_done_o(hartDone1), .hart_pass_o(hartPass1),
    .cycles_o(cycles1)
  );

  rv32i_test_ctrl #(
    .NUM_HARTS(4), .XLEN(32), .RESET_CYCLES(4), .CNT_W(16), .PASS_VALUE(32'd1)
  ) dut4 (
    .clk_i(clk), .rst_i(rst4), .start_i(start4), .wait_all_i(waitAll4),
    .timeout_limit_i(limit4), .ecall_i(ecall4), .gp_i(gp4),
    .core_rst_n_o(coreRstN4), .halt_o(halt4), .busy_o(busy4), .done_o(done4),
    .result_o(result4), .hart_done_o(hartDone4), .hart_pass_o(hartPass4),
    .cycles_o(cycles4)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the main sequence ever stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance n falling edges with the current inputs held.
  task automatic applyStimulus(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One comparison: count it, then report a failure with tag and values.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Count falling edges, including the current one, on which core reset is
  // still asserted. The count is bounded so that a stuck design cannot hang
  // the bench. An overrun then shows up as a wrong count.
  task automatic waitRun1(output int n);
    n = 0;
    while (coreRstN1 === 1'b0 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic waitRun4(output int n);
    n = 0;
    while (coreRstN4 === 1'b0 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst1 = 1'b1; start1 = 1'b0; waitAll1 = 1'b0; limit1 = '0; ecall1 = '0; gp1 = '0;
    rst4 = 1'b1; start4 = 1'b0; waitAll4 = 1'b0; limit4 = '0; ecall4 = '0; gp4 = '0;

    // ---- reset values ----
    applyStimulus(2);
    checkOutput("rst1 core_rst_n", 32'(coreRstN1), 0);
    checkOutput("rst1 halt",       32'(halt1),     1);
    checkOutput("rst1 busy",       32'(busy1),     0);
    checkOutput("rst1 done",       32'(done1),     0);
    checkOutput("rst1 result",     32'(result1),   0);
    checkOutput("rst1 cycles",     32'(cycles1),   0);
    checkOutput("rst4 hart_done",  32'(hartDone4), 0);
    checkOutput("rst4 hart_pass",  32'(hartPass4), 0);
    checkOutput("rst4 halt",       32'(halt4),     1);
    rst1 = 1'b0; rst4 = 1'b0;
    applyStimulus(1);
    checkOutput("idle1 busy", 32'(busy1), 0);

    // ---- 1 hart: pass at RUN cycle 20 ----
    start1 = 1'b1;
    applyStimulus(1);
    start1 = 1'b0;
    checkOutput("s1 busy in reset", 32'(busy1), 1);
    checkOutput("s1 halt in reset", 32'(halt1), 0);
    waitRun1(lowCycles);
    checkOutput("s1 reset length", 32'(lowCycles), 10);
    checkOutput("s1 cycles at run entry", 32'(cycles1), 0);
    applyStimulus(20);
    checkOutput("s1 cycles before ecall", 32'(cycles1), 20);
    ecall1 = 1'b1; gp1 = 32'd1;
    applyStimulus(1);
    ecall1 = 1'b0;
    checkOutput("s1 done",       32'(done1),     1);
    checkOutput("s1 result",     32'(result1),   1);
    checkOutput("s1 cycles",     32'(cycles1),   21);
    checkOutput("s1 halt",       32'(halt1),     1);
    checkOutput("s1 busy",       32'(busy1),     0);
    checkOutput("s1 core_rst_n", 32'(coreRstN1), 1);
    checkOutput("s1 hart_pass",  32'(hartPass1), 1);
    applyStimulus(3);
    checkOutput("s1 cycles frozen", 32'(cycles1), 21);
    checkOutput("s1 done held",     32'(done1),   1);

    // ---- 1 hart: fail with gp=5, restarted from DONE ----
    start1 = 1'b1;
    applyStimulus(1);
    start1 = 1'b0;
    checkOutput("s2 done cleared",   32'(done1),     0);
    checkOutput("s2 result cleared", 32'(result1),   0);
    checkOutput("s2 hart_done clr",  32'(hartDone1), 0);
    checkOutput("s2 cycles cleared", 32'(cycles1),   0);
    checkOutput("s2 core_rst_n",     32'(coreRstN1), 0);
    waitRun1(lowCycles);
    checkOutput("s2 reset length", 32'(lowCycles), 10);
    applyStimulus(20);
    ecall1 = 1'b1; gp1 = 32'd5;
    applyStimulus(1);
    ecall1 = 1'b0;
    checkOutput("s2 done",      32'(done1),     1);
    checkOutput("s2 result",    32'(result1),   2);
    checkOutput("s2 hart_done", 32'(hartDone1), 1);
    checkOutput("s2 hart_pass", 32'(hartPass1), 0);

    // ---- 1 hart: timeout 50 (limit latched, ecall in RESET ignored) ----
    limit1 = 16'd50;
    start1 = 1'b1;
    applyStimulus(1);
    start1 = 1'b0;
    limit1 = 16'd7;
    ecall1 = 1'b1; gp1 = 32'd1;
    waitRun1(lowCycles);
    ecall1 = 1'b0;
    checkOutput("s3 hart_done after reset ecall", 32'(hartDone1), 0);
    applyStimulus(49);
    checkOutput("s3 cycles before limit", 32'(cycles1), 49);
    checkOutput("s3 not done yet",        32'(done1),   0);
    applyStimulus(1);
    checkOutput("s3 done",      32'(done1),     1);
    checkOutput("s3 result",    32'(result1),   3);
    checkOutput("s3 cycles",    32'(cycles1),   50);
    checkOutput("s3 hart_done", 32'(hartDone1), 0);

    // ---- 1 hart: ecall on the last cycle beats the timeout ----
    limit1 = 16'd50;
    start1 = 1'b1;
    applyStimulus(1);
    start1 = 1'b0;
    waitRun1(lowCycles);
    applyStimulus(49);
    ecall1 = 1'b1; gp1 = 32'd1;
    applyStimulus(1);
    ecall1 = 1'b0;
    checkOutput("s3b done",   32'(done1),   1);
    checkOutput("s3b result", 32'(result1), 1);
    checkOutput("s3b cycles", 32'(cycles1), 50);

    // ---- 4 harts, wait_all: ecalls at 5, 9, 9, 30 with gp 1, 1, 7, 1 ----
    waitAll4 = 1'b1;
    start4 = 1'b1;
    applyStimulus(1);
    start4 = 1'b0;
    waitAll4 = 1'b0;
    waitRun4(lowCycles);
    checkOutput("s4 reset length", 32'(lowCycles), 4);
    applyStimulus(5);
    ecall4 = 4'b0001; gp4 = '0; gp4[0 +: 32] = 32'd1;
    applyStimulus(1);
    ecall4 = 4'b0000;
    checkOutput("s4 hart_done h0", 32'(hartDone4), 32'h1);
    checkOutput("s4 still running", 32'(done4), 0);
    applyStimulus(3);
    ecall4 = 4'b0110; gp4[32 +: 32] = 32'd1; gp4[64 +: 32] = 32'd7;
    applyStimulus(1);
    ecall4 = 4'b0000;
    checkOutput("s4 hart_done h012", 32'(hartDone4), 32'h7);
    checkOutput("s4 hart_pass h012", 32'(hartPass4), 32'h3);
    applyStimulus(2);
    ecall4 = 4'b0001; gp4[0 +: 32] = 32'd7;
    applyStimulus(1);
    ecall4 = 4'b0000;
    checkOutput("s4 repeat ecall pass", 32'(hartPass4), 32'h3);
    checkOutput("s4 repeat ecall done", 32'(done4),     0);
    checkOutput("s4 cycles mid",        32'(cycles4),   13);
    applyStimulus(17);
    ecall4 = 4'b1000; gp4[96 +: 32] = 32'd1;
    applyStimulus(1);
    ecall4 = 4'b0000;
    checkOutput("s4 done",      32'(done4),     1);
    checkOutput("s4 result",    32'(result4),   2);
    checkOutput("s4 hart_pass", 32'(hartPass4), 32'hB);
    checkOutput("s4 hart_done", 32'(hartDone4), 32'hF);
    checkOutput("s4 cycles",    32'(cycles4),   31);

    // ---- 4 harts, first ecall wins: hart 2 passes at cycle 12 ----
    gp4 = '0;
    start4 = 1'b1;
    applyStimulus(1);
    start4 = 1'b0;
    waitRun4(lowCycles);
    applyStimulus(12);
    ecall4 = 4'b0100; gp4[64 +: 32] = 32'd1;
    applyStimulus(1);
    ecall4 = 4'b0000;
    checkOutput("s5 done",      32'(done4),     1);
    checkOutput("s5 result",    32'(result4),   1);
    checkOutput("s5 hart_done", 32'(hartDone4), 32'h4);
    checkOutput("s5 hart_pass", 32'(hartPass4), 32'h4);
    checkOutput("s5 cycles",    32'(cycles4),   13);
    start4 = 1'b1;
    applyStimulus(1);
    start4 = 1'b0;
    checkOutput("s5 restart done",      32'(done4),     0);
    checkOutput("s5 restart hart_done", 32'(hartDone4), 0);
    checkOutput("s5 restart hart_pass", 32'(hartPass4), 0);
    checkOutput("s5 restart result",    32'(result4),   0);
    checkOutput("s5 restart core_rst",  32'(coreRstN4), 0);
    checkOutput("s5 restart busy",      32'(busy4),     1);

    // ---- 4 harts: rst mid-RUN, then a fresh run with start in RESET ----
    waitRun4(lowCycles);
    applyStimulus(5);
    checkOutput("s6 running before rst", 32'(busy4), 1);
    rst4 = 1'b1;
    applyStimulus(1);
    rst4 = 1'b0;
    checkOutput("s6 rst core_rst_n", 32'(coreRstN4), 0);
    checkOutput("s6 rst halt",       32'(halt4),     1);
    checkOutput("s6 rst busy",       32'(busy4),     0);
    checkOutput("s6 rst cycles",     32'(cycles4),   0);
    applyStimulus(2);
    checkOutput("s6 idle after rst", 32'(busy4), 0);
    start4 = 1'b1;
    applyStimulus(1);
    applyStimulus(1);
    start4 = 1'b0;
    waitRun4(lowCycles);
    checkOutput("s6 reset length with start in RESET", 32'(lowCycles + 1), 4);
    applyStimulus(3);
    ecall4 = 4'b0010; gp4 = '0; gp4[32 +: 32] = 32'd1;
    applyStimulus(1);
    ecall4 = 4'b0000;
    checkOutput("s6 done",      32'(done4),     1);
    checkOutput("s6 result",    32'(result4),   1);
    checkOutput("s6 hart_done", 32'(hartDone4), 32'h2);
    checkOutput("s6 cycles",    32'(cycles4),   4);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
